// File: rtl/adc_spi_sampler.sv
// adc_spi_sampler: runs the 16-bit SPI read frame of an external 12-bit serial ADC
// (4 leading zeros, then 12 data bits MSB first) on each single-cycle sample request and
// returns the result as a one-cycle adc_valid_o strobe alongside adc_data_o.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   sample_req_i  single-cycle conversion request (accepted only when idle)
//   adc_sdo_i     serial data from the ADC, captured on the SCLK 0->1 edge
//   adc_cs_n_o    ADC chip select, active low
//   adc_sclk_o    SPI clock, idles high
//   adc_data_o    last good conversion result
//   adc_valid_o   one-cycle strobe, adc_data_o is new
//   busy_o        high whenever the FSM is not idle
//   frame_err_o   one-cycle strobe, a leading frame bit was nonzero
//   overrun_o     one-cycle strobe, a request arrived while busy and was dropped
module adc_spi_sampler #(
    parameter int unsigned CLK_DIV      = 4,  // SCLK half-period in clk cycles, >= 2
    parameter int unsigned QUIET_CYCLES = 8   // minimum CS_n-high time after a frame, >= 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_req_i,
    input  logic        adc_sdo_i,
    output logic        adc_cs_n_o,
    output logic        adc_sclk_o,
    output logic [11:0] adc_data_o,
    output logic        adc_valid_o,
    output logic        busy_o,
    output logic        frame_err_o,
    output logic        overrun_o
);

    localparam int unsigned MaxCnt = (CLK_DIV > QUIET_CYCLES) ? CLK_DIV : QUIET_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);

    localparam logic [CntW-1:0] DivLast   = CntW'(CLK_DIV - 1);
    localparam logic [CntW-1:0] QuietLast = CntW'(QUIET_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne    = CntW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StShift,
        StQuiet
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;      // phase counter shared by SETUP, SHIFT half-periods and QUIET
    logic [3:0]      bit_cnt_q;  // index of the current bit period within the frame
    logic [15:0]     shift_q;
    logic            cs_n_q;
    logic            sclk_q;
    logic [11:0]     data_q;
    logic            valid_q;
    logic            err_q;
    logic            ovr_q;
    logic            busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b1;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            // Requests are never queued: anything outside IDLE is reported and dropped.
            ovr_q   <= sample_req_i && (state_q != StIdle);

            unique case (state_q)
                StIdle: begin
                    if (sample_req_i) begin
                        state_q <= StSetup;
                        cs_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end

                StSetup: begin
                    if (cnt_q == DivLast) begin
                        state_q   <= StShift;
                        sclk_q    <= 1'b0;
                        cnt_q     <= '0;
                        bit_cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end

                StShift: begin
                    if (cnt_q == DivLast) begin
                        cnt_q <= '0;
                        if (!sclk_q) begin
                            // End of low phase: SCLK rises on this edge, sample SDO here.
                            sclk_q  <= 1'b1;
                            shift_q <= {shift_q[14:0], adc_sdo_i};
                        end else if (bit_cnt_q == 4'd15) begin
                            // End of the 16th high phase closes the frame.
                            state_q   <= StQuiet;
                            cs_n_q    <= 1'b1;
                            bit_cnt_q <= '0;
                            if (shift_q[15:12] == 4'd0) begin
                                data_q  <= shift_q[11:0];
                                valid_q <= 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end else begin
                            sclk_q    <= 1'b0;
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end

                StQuiet: begin
                    if (cnt_q == QuietLast) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign adc_cs_n_o  = cs_n_q;
    assign adc_sclk_o  = sclk_q;
    assign adc_data_o  = data_q;
    assign adc_valid_o = valid_q;
    assign busy_o      = busy_q;
    assign frame_err_o = err_q;
    assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Self-checking bench for adc_spi_sampler. Expected waveforms come from closed-form timing
// (cycle offsets from the request) and the frame-acceptance rule; ADC behaviour is modelled
// as a device that presents frame bit (16-n) after the n-th SCLK falling edge of a frame.
module tb_adc_spi_sampler;

    localparam int D  = 4;
    localparam int Q  = 8;
    localparam int E  = 33 * D;     // last cycle offset with CS_n low
    localparam int P  = 1 + E + Q;  // minimum request period
    localparam int D2 = 2;
    localparam int Q2 = 1;
    localparam int E2 = 33 * D2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic        req1 = 1'b0, sdo1, cs1, sclk1, valid1, busy1, err1, ovr1;
    logic [11:0] data1;
    logic        req2 = 1'b0, sdo2, cs2, sclk2, valid2, busy2, err2, ovr2;
    logic [11:0] data2;

    logic [15:0] frame1 = 16'h0000;
    logic [15:0] frame2 = 16'h0000;
    int          nfall1 = 0;
    int          nfall2 = 0;

    always #5 clk = ~clk;

    adc_spi_sampler #(.CLK_DIV(D), .QUIET_CYCLES(Q)) dut (
        .clk(clk), .rst_n(rst_n), .sample_req_i(req1), .adc_sdo_i(sdo1),
        .adc_cs_n_o(cs1), .adc_sclk_o(sclk1), .adc_data_o(data1), .adc_valid_o(valid1),
        .busy_o(busy1), .frame_err_o(err1), .overrun_o(ovr1)
    );

    adc_spi_sampler #(.CLK_DIV(D2), .QUIET_CYCLES(Q2)) dut2 (
        .clk(clk), .rst_n(rst_n), .sample_req_i(req2), .adc_sdo_i(sdo2),
        .adc_cs_n_o(cs2), .adc_sclk_o(sclk2), .adc_data_o(data2), .adc_valid_o(valid2),
        .busy_o(busy2), .frame_err_o(err2), .overrun_o(ovr2)
    );

    // ADC model: bit (16-n) of the frame is driven after the n-th falling SCLK edge.
    function automatic logic adc_bit(input logic [15:0] f, input int n);
        logic [15:0] s;
        if (n < 1 || n > 16) return 1'b0;
        s = f << (n - 1);
        return s[15];
    endfunction

    always @(negedge sclk1 or posedge cs1) begin
        if (cs1) nfall1 <= 0;
        else     nfall1 <= nfall1 + 1;
    end
    always @(negedge sclk2 or posedge cs2) begin
        if (cs2) nfall2 <= 0;
        else     nfall2 <= nfall2 + 1;
    end
    always_comb sdo1 = adc_bit(frame1, nfall1);
    always_comb sdo2 = adc_bit(frame2, nfall2);

    int          chk = 0;
    int          errs = 0;
    logic [11:0] exp_data = 12'h000;
    bit          ovr_pending = 1'b0;

    int          bad  [8];
    int          fcyc [8];
    logic [31:0] fobs [8];
    logic [31:0] fexp [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_agg();
        for (int i = 0; i < 8; i++) bad[i] = 0;
    endtask

    task automatic note(input int i, input logic [31:0] obs, input logic [31:0] exp,
                        input int t);
        if (obs !== exp) begin
            if (bad[i] == 0) begin
                fcyc[i] = t;
                fobs[i] = obs;
                fexp[i] = exp;
            end
            bad[i]++;
        end
    endtask

    task automatic report(input int i, input string tag);
        chk++;
        assert (bad[i] == 0) else begin
            errs++;
            $error("FAIL %s: %0d bad cycles, first at t=%0d observed=%0h expected=%0h",
                   tag, bad[i], fcyc[i], fobs[i], fexp[i]);
        end
    endtask

    task automatic report_all(input string pfx);
        report(0, {pfx, "_cs_n"});
        report(1, {pfx, "_sclk"});
        report(2, {pfx, "_busy"});
        report(3, {pfx, "_valid"});
        report(4, {pfx, "_frame_err"});
        report(5, {pfx, "_overrun"});
        report(6, {pfx, "_data"});
    endtask

    task automatic idle_check(input int n, input string pfx);
        clear_agg();
        req1 = 1'b0;
        for (int t = 0; t < n; t++) begin
            note(0, 32'(cs1), 32'd1, t);
            note(1, 32'(sclk1), 32'd1, t);
            note(2, 32'(busy1), 32'd0, t);
            note(3, 32'(valid1), 32'd0, t);
            note(4, 32'(err1), 32'd0, t);
            note(5, 32'(ovr1), (t == 0) ? 32'(ovr_pending) : 32'd0, t);
            note(6, 32'(data1), 32'(exp_data), t);
            step();
        end
        ovr_pending = 1'b0;
        report_all(pfx);
    endtask

    // One request at offset 0, optional extra requests at offsets x0..x2 (-1 = none),
    // optional reset pulse at offset rst_at (-1 = none). Covers P cycles when not reset.
    task automatic run_frame(input logic [15:0] f, input int x0, input int x1, input int x2,
                             input int rst_at, input string pfx);
        bit          good;
        bit          aborted;
        logic [11:0] new_data;
        int          rises;
        logic        prev_sclk;
        int          r;
        bit          sclk_exp;
        frame1   = f;
        good     = (f[15:12] == 4'd0);
        new_data = good ? f[11:0] : exp_data;
        rises    = 0;
        aborted  = 1'b0;
        prev_sclk = sclk1;
        clear_agg();
        for (int t = 0; t < P; t++) begin
            if (t == rst_at) begin
                req1 = 1'b0;
                #2 rst_n = 1'b0;
                #1;
                check({pfx, "_rst_cs_n"}, 32'(cs1), 32'd1);
                check({pfx, "_rst_sclk"}, 32'(sclk1), 32'd1);
                check({pfx, "_rst_busy"}, 32'(busy1), 32'd0);
                check({pfx, "_rst_valid"}, 32'(valid1), 32'd0);
                check({pfx, "_rst_data"}, 32'(data1), 32'd0);
                step();
                step();
                rst_n       = 1'b1;
                exp_data    = 12'h000;
                ovr_pending = 1'b0;
                aborted     = 1'b1;
                break;
            end
            sclk_exp = 1'b1;
            if (t >= 1 + D && t <= E) sclk_exp = (((t - 1 - D) / D) % 2) == 1;
            r = t - 1;
            note(0, 32'(cs1), (t >= 1 && t <= E) ? 32'd0 : 32'd1, t);
            note(1, 32'(sclk1), 32'(sclk_exp), t);
            note(2, 32'(busy1), (t >= 1 && t <= E + Q) ? 32'd1 : 32'd0, t);
            note(3, 32'(valid1), (good && t == E + 1) ? 32'd1 : 32'd0, t);
            note(4, 32'(err1), (!good && t == E + 1) ? 32'd1 : 32'd0, t);
            if (t == 0) note(5, 32'(ovr1), 32'(ovr_pending), t);
            else note(5, 32'(ovr1),
                      ((r == x0 || r == x1 || r == x2) && r >= 1 && r <= E + Q) ? 32'd1 : 32'd0,
                      t);
            note(6, 32'(data1), (t >= E + 1) ? 32'(new_data) : 32'(exp_data), t);
            if (!prev_sclk && sclk1 && !cs1) rises++;
            prev_sclk = sclk1;
            req1 = (t == 0) || (t == x0) || (t == x1) || (t == x2);
            step();
        end
        req1 = 1'b0;
        report_all(pfx);
        if (!aborted) begin
            check({pfx, "_sclk_rises"}, 32'(rises), 32'd16);
            exp_data    = new_data;
            ovr_pending = (x0 == P - 1) || (x1 == P - 1) || (x2 == P - 1);
        end
    endtask

    initial begin
        logic [15:0] f;
        logic [3:0]  lead;
        int          xa;
        int          xb;

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // Reset state.
        idle_check(5, "reset");

        // Single frame 0x0ABC: valid at 133 only.
        run_frame(16'h0ABC, -1, -1, -1, -1, "f_0abc");
        check("data_0abc", 32'(data1), 32'h0ABC);

        // Back-to-back frames at the minimum period, no overrun.
        run_frame(16'h0FFF, -1, -1, -1, -1, "f_0fff");
        run_frame(16'h0000, -1, -1, -1, -1, "f_0000");
        check("data_0000", 32'(data1), 32'h000);

        // Good frame then a framing error: data must hold.
        run_frame(16'h0555, -1, -1, -1, -1, "f_0555");
        run_frame(16'h8123, -1, -1, -1, -1, "f_8123");
        check("data_hold_555", 32'(data1), 32'h555);

        // Dropped requests at 50, 133 (valid cycle) and 140 (last quiet cycle),
        // then a request at 141 is accepted.
        run_frame(16'h0321, 50, E + 1, P - 1, -1, "f_ovr");
        run_frame(16'h0456, -1, -1, -1, -1, "f_after_ovr");
        check("data_0456", 32'(data1), 32'h456);

        // Reset mid-frame at cycle 70, then a clean frame.
        idle_check(3, "pre_rst");
        run_frame(16'h0777, -1, -1, -1, 70, "f_rst");
        idle_check(4, "post_rst");
        run_frame(16'h0ABC, -1, -1, -1, -1, "f_after_rst");
        check("data_after_rst", 32'(data1), 32'h0ABC);

        // Randomized frames, occasional framing errors and stray requests.
        for (int k = 0; k < 8; k++) begin
            lead = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            f    = {lead, 12'($urandom)};
            xa   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, P - 1)) : -1;
            xb   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, P - 1)) : -1;
            run_frame(f, xa, xb, -1, -1, $sformatf("rand%0d", k));
            if ($urandom_range(0, 1) == 1) idle_check(int'($urandom_range(1, 6)),
                                                      $sformatf("gap%0d", k));
        end

        // Fast configuration: CLK_DIV=2, QUIET_CYCLES=1.
        frame2 = 16'h0A5A;
        clear_agg();
        for (int t = 0; t < E2 + Q2 + 5; t++) begin
            note(0, 32'(cs2), (t >= 1 && t <= E2) ? 32'd0 : 32'd1, t);
            note(2, 32'(busy2), (t >= 1 && t <= E2 + Q2) ? 32'd1 : 32'd0, t);
            note(3, 32'(valid2), (t == E2 + 1) ? 32'd1 : 32'd0, t);
            note(4, 32'(err2), 32'd0, t);
            note(5, 32'(ovr2), 32'd0, t);
            note(6, 32'(data2), (t >= E2 + 1) ? 32'h0A5A : 32'h000, t);
            req2 = (t == 0);
            step();
        end
        req2 = 1'b0;
        report(0, "fast_cs_n");
        report(2, "fast_busy");
        report(3, "fast_valid");
        report(4, "fast_frame_err");
        report(5, "fast_overrun");
        report(6, "fast_data");

        $display("Result: errors=%0d of %0d checks", errs, chk);
        $finish;
    end

endmodule

// File: doc/adc_spi_sampler.md
# adc_spi_sampler

Producer side of the `adc_data`/`adc_valid` feedback path. It runs the SPI read frame of an external 12-bit serial ADC (16-bit frame: 4 leading zeros, then 12 data bits MSB first) on each sample request. It delivers the result as a one-cycle `adc_valid` strobe with `adc_data`, which connect directly to the inputs of `adc_interface` in `buck_converter_top`. Sample requests come from the PWM timing logic, e.g. the mid-on-time point.

## Interface
- CLK_DIV, 4: SCLK half-period in clk cycles; legal ≥ 2
- QUIET_CYCLES, 8: minimum CS_n-high time after a frame, in clk cycles; legal ≥ 1
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- sample_req  input  1  single-cycle conversion request
- adc_sdo  input  1  serial data from the ADC
- adc_cs_n  output  1  ADC chip select, active low
- adc_sclk  output  1  SPI clock, idles high
- adc_data  output  12  last good conversion result
- adc_valid  output  1  one-cycle strobe; `adc_data` is new
- busy  output  1  high whenever the FSM is not in IDLE
- frame_err  output  1  one-cycle strobe; a leading bit was nonzero
- overrun  output  1  one-cycle strobe; `sample_req` was dropped

## Operation
- FSM states: IDLE → SETUP → SHIFT → QUIET → IDLE.
- IDLE: `adc_cs_n`=1, `adc_sclk`=1. A `sample_req` in this state moves the FSM to SETUP and drives `adc_cs_n` to 0.
- SETUP: lasts CLK_DIV cycles with `adc_sclk` high, then moves to SHIFT.
- SHIFT: 16 bit periods. Each bit period is `adc_sclk` low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - `adc_sdo` is captured into a 16-bit shift register, MSB first, on the clk edge where `adc_sclk` goes 0→1.
  - A bit counter (0..15) advances at the end of each high phase.
- End of frame: on the edge that ends the 16th high phase, all of the following happen:
  - `adc_cs_n` goes to 1 and `adc_sclk` stays 1.
  - If shift bits [15:12] == 0: `adc_data` ← bits [11:0] and `adc_valid` pulses.
  - Otherwise: `frame_err` pulses and `adc_data` holds its previous value.
  - The FSM enters QUIET.
- QUIET: lasts QUIET_CYCLES cycles, then the FSM returns to IDLE.
- A `sample_req` in any state other than IDLE is dropped and pulses `overrun` in the following cycle. Requests are never queued.
- `adc_valid` and `frame_err` are mutually exclusive.
- `adc_sdo` is sampled without a synchronizer. SPI timing is closed by constraints.

## Timing
- Reset values: `adc_cs_n`=1, `adc_sclk`=1, `adc_data`=0, `adc_valid`=0, `busy`=0, `frame_err`=0, `overrun`=0. The FSM resets to IDLE and all counters reset to 0.
- Let `sample_req` be high in cycle 0, with the FSM in IDLE.
  - `adc_cs_n`=0 and `busy`=1 from cycle 1.
  - First `adc_sclk` falling edge appears in cycle 1+CLK_DIV.
  - `adc_valid` (or `frame_err`) is high in cycle 1+33·CLK_DIV, which is cycle 133 at the default. `adc_cs_n` returns high in the same cycle.
  - `busy` falls in cycle 1+33·CLK_DIV+QUIET_CYCLES.
  - The earliest accepted next request is in that same cycle.
- Minimum request period: 1+33·CLK_DIV+QUIET_CYCLES cycles, which is 141 at the defaults.
- A `sample_req` coinciding with the `adc_valid` cycle, or with the last QUIET cycle, is dropped and produces `overrun`.
- All outputs are registered. Outputs are glitch-free on `adc_cs_n` and `adc_sclk`.
- Reset asserted mid-frame:
  - Outputs immediately go to their reset values; `adc_cs_n` rises asynchronously.
  - No `adc_valid` and no `frame_err` is produced.
  - After release, the FSM is in IDLE and the first `sample_req` starts a clean frame.

## Test plan
- ADC model returns 0x0ABC; single `sample_req` at cycle 0 → `adc_valid` only in cycle 133, `adc_data`=0xABC, exactly 16 `adc_sclk` rising edges while `adc_cs_n`=0.
- Model returns 0x0FFF, then 0x0000, with requests 141 cycles apart → two `adc_valid` pulses, `adc_data`=0xFFF then 0x000, `overrun` never asserted.
- Model returns 0x8123 after a good 0x0555 frame → `frame_err` pulses in cycle 133, no `adc_valid`, `adc_data` stays 0x555.
- Second `sample_req` at cycles 50, 133 and 140 → `overrun` pulse one cycle after each, frame unaffected; a request at cycle 141 is accepted.
- `rst_n` pulsed low at cycle 70 mid-frame → `adc_cs_n`=1 and `adc_sclk`=1 immediately, no `adc_valid`; a request after release yields a correct result 133 cycles later.
- CLK_DIV=2, QUIET_CYCLES=1, data 0x0A5A → `adc_valid` at cycle 67 with 0xA5A, `busy` low at cycle 68.
